// File: rtl/uart_tx_datapath.sv
// UART transmitter datapath: frame shift register, baud-tick counter and bit counter.
// Optional parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_datapath #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] dataIn,
    input  logic                 load,
    input  logic                 shift,
    input  logic                 incNumBits,
    input  logic                 resetBaudTickCounter,
    output logic                 baudTickCounterDone,
    output logic                 bitCounterDone,
    output logic                 tx
);

`ifdef UART_TX_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned FRAME_W = DATA_BITS + 2 + PAR_W;
    localparam int unsigned BCW     = $clog2(BAUD_DIV);
    localparam int unsigned NBW     = $clog2(FRAME_W);

    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [NBW-1:0] BIT_LAST  = NBW'(FRAME_W - 1);

    // Reject parameter sets the frame format cannot represent.
    if (DATA_BITS < 5 || DATA_BITS > 9 || BAUD_DIV < 2 || PARITY_ODD > 1) begin : g_param_check
        $fatal(1, "uart_tx_datapath: illegal parameter set");
    end

    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [BCW-1:0]     baud_cnt_q, baud_cnt_d;
    logic [NBW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] frame_load;

`ifdef UART_TX_PARITY_EN
    logic parity_bit;

    assign parity_bit = (^dataIn) ^ (PARITY_ODD != 0);
    assign frame_load = {1'b1, parity_bit, dataIn, 1'b0};
`else
    assign frame_load = {1'b1, dataIn, 1'b0};
`endif

    // Next-state for frame register and both counters; load dominates.
    always_comb begin
        frame_d    = frame_q;
        baud_cnt_d = baud_cnt_q + BCW'(1);
        bit_cnt_d  = bit_cnt_q;

        if (load) begin
            frame_d = frame_load;
        end else if (shift) begin
            frame_d = {1'b1, frame_q[FRAME_W-1:1]};
        end

        if (load || resetBaudTickCounter || (baud_cnt_q == BAUD_LAST)) begin
            baud_cnt_d = '0;
        end

        if (load) begin
            bit_cnt_d = '0;
        end else if (incNumBits && (bit_cnt_q != BIT_LAST)) begin
            bit_cnt_d = bit_cnt_q + NBW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q    <= '1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            frame_q    <= frame_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign tx                  = frame_q[0];
    assign baudTickCounterDone = (baud_cnt_q == BAUD_LAST);
    assign bitCounterDone      = baudTickCounterDone && (bit_cnt_q == BIT_LAST);

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Directed self-checking bench for uart_tx_datapath (BAUD_DIV = 4, DATA_BITS = 8).
module tb_uart_tx_datapath;

`ifdef UART_TX_PARITY_EN
    localparam int FW = 11;
`else
    localparam int FW = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] dataIn;
    logic       load;
    logic       shift;
    logic       incNumBits;
    logic       resetBaudTickCounter;
    logic       baudTickCounterDone;
    logic       bitCounterDone;
    logic       tx;

    int checks = 0;
    int errors = 0;

    uart_tx_datapath #(
        .DATA_BITS (8),
        .BAUD_DIV  (4),
        .PARITY_ODD(0)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .dataIn              (dataIn),
        .load                (load),
        .shift               (shift),
        .incNumBits          (incNumBits),
        .resetBaudTickCounter(resetBaudTickCounter),
        .baudTickCounterDone (baudTickCounterDone),
        .bitCounterDone      (bitCounterDone),
        .tx                  (tx)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Loads a frame, then acts as the Tx FSM: shift and count on every baud tick.
    task automatic run_frame(input string name, input logic [7:0] din, input logic [10:0] exp, input int nb);
        logic exp_tx;
        dataIn = din;
        load   = 1'b1;
        tick;
        load   = 1'b0;
        for (int c = 1; c <= nb * 4 + 1; c++) begin
            exp_tx = (c > nb * 4) ? 1'b1 : exp[(c - 1) / 4];
            check({name, "_tx"}, 32'(tx), 32'(exp_tx));
            check({name, "_done"}, 32'(bitCounterDone), 32'(c == nb * 4));
            shift      = baudTickCounterDone;
            incNumBits = baudTickCounterDone;
            tick;
        end
        shift      = 1'b0;
        incNumBits = 1'b0;
    endtask

    initial begin
        logic [10:0] exp_a5;
        reset                = 1'b1;
        dataIn               = 8'h00;
        load                 = 1'b0;
        shift                = 1'b0;
        incNumBits           = 1'b0;
        resetBaudTickCounter = 1'b0;

        // Reset state
        tick;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_baud_done", 32'(baudTickCounterDone), 32'd0);
        check("rst_bit_done", 32'(bitCounterDone), 32'd0);
        check("rst_baud_cnt", 32'(dut.baud_cnt_q), 32'd0);
        check("rst_bit_cnt", 32'(dut.bit_cnt_q), 32'd0);
        reset = 1'b0;
        tick;

        // Frame shape for 8'hA5
`ifdef UART_TX_PARITY_EN
        exp_a5 = 11'b1_0_10100101_0;
        run_frame("frame_a5", 8'hA5, exp_a5, 11);
`else
        exp_a5 = 11'b0_1_10100101_0;
        run_frame("frame_a5", 8'hA5, exp_a5, 10);
`endif

        // Reset mid-frame, after three bits have gone out
        dataIn = 8'h00;
        load   = 1'b1;
        tick;
        load   = 1'b0;
        for (int c = 1; c < 14; c++) begin
            shift      = baudTickCounterDone;
            incNumBits = baudTickCounterDone;
            tick;
        end
        shift      = 1'b0;
        incNumBits = 1'b0;
        check("midframe_tx", 32'(tx), 32'd0);
        check("midframe_bit_cnt", 32'(dut.bit_cnt_q), 32'd3);
        reset = 1'b1;
        #1;
        check("async_rst_tx", 32'(tx), 32'd1);
        check("async_rst_baud_done", 32'(baudTickCounterDone), 32'd0);
        check("async_rst_bit_done", 32'(bitCounterDone), 32'd0);
        tick;
        check("held_rst_tx", 32'(tx), 32'd1);
        reset = 1'b0;
        #1;
        check("post_rst_baud_cnt", 32'(dut.baud_cnt_q), 32'd0);
        check("post_rst_bit_cnt", 32'(dut.bit_cnt_q), 32'd0);

        // Free-running baud counter, then clear when baudCnt = 2
        for (int k = 1; k <= 10; k++) begin
            tick;
            check("baud_free_done", 32'(baudTickCounterDone), 32'(k % 4 == 3));
        end
        check("baud_cnt_before_clear", 32'(dut.baud_cnt_q), 32'd2);
        resetBaudTickCounter = 1'b1;
        for (int k = 11; k <= 15; k++) begin
            tick;
            resetBaudTickCounter = 1'b0;
            check("baud_clear_done", 32'(baudTickCounterDone), 32'(k == 14));
        end

        // Priority: load beats shift and incNumBits
        incNumBits = 1'b1;
        tick;
        tick;
        tick;
        incNumBits = 1'b0;
        check("pre_prio_bit_cnt", 32'(dut.bit_cnt_q), 32'd3);
        dataIn     = 8'h00;
        load       = 1'b1;
        shift      = 1'b1;
        incNumBits = 1'b1;
        tick;
        load       = 1'b0;
        shift      = 1'b0;
        incNumBits = 1'b0;
`ifdef UART_TX_PARITY_EN
        check("prio_frame", 32'(dut.frame_q), 32'(11'b10000000000));
`else
        check("prio_frame", 32'(dut.frame_q), 32'(10'b1000000000));
`endif
        check("prio_bit_cnt", 32'(dut.bit_cnt_q), 32'd0);
        check("prio_tx", 32'(tx), 32'd0);

        // Saturation: 15 increments, counter holds at FW-1
        incNumBits = 1'b1;
        for (int i = 0; i < 15; i++) tick;
        incNumBits = 1'b0;
        check("sat_bit_cnt", 32'(dut.bit_cnt_q), 32'(FW - 1));
        for (int c = 16; c <= 23; c++) begin
            check("sat_baud_done", 32'(baudTickCounterDone), 32'((c - 1) % 4 == 3));
            check("sat_bit_done", 32'(bitCounterDone), 32'((c - 1) % 4 == 3));
            tick;
        end
        check("sat_bit_cnt_hold", 32'(dut.bit_cnt_q), 32'(FW - 1));

`ifdef UART_TX_PARITY_EN
        // Even parity over 8'h07 is 1
        run_frame("parity_07", 8'h07, 11'b1_1_00000111_0, 11);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_datapath.md
Name: uart_tx_datapath

Overview:
- Datapath of the UART transmitter. Its control inputs (load, shift, incNumBits, resetBaudTickCounter) are driven by the Tx FSM.
- Returns the status flags baudTickCounterDone and bitCounterDone to the FSM.
- Holds the frame shift register, the baud-tick counter and the bit counter, and drives the serial line tx.

Parameters:
- DATA_BITS, 8, number of data bits per frame, LSB first; legal range 5..9.
- BAUD_DIV, 868, clk cycles per bit (100 MHz / 115200); must be >= 2.
- PARITY_ODD, 0, parity sense (0 = even, 1 = odd); used only when UART_TX_PARITY_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- dataIn  in  DATA_BITS  byte to transmit; sampled only on load.
- load  in  1  from FSM: capture frame, clear both counters.
- shift  in  1  from FSM: advance frame register one bit.
- incNumBits  in  1  from FSM: increment bit counter.
- resetBaudTickCounter  in  1  from FSM: clear baud-tick counter.
- baudTickCounterDone  out  1  to FSM: last cycle of current bit period.
- bitCounterDone  out  1  to FSM: last cycle of last bit of the frame.
- tx  out  1  serial output, idle high.

Behaviour:
- FRAME_W = DATA_BITS + 2 (start + stop); DATA_BITS + 3 with parity. BCW = clog2(BAUD_DIV). NBW = clog2(FRAME_W).
- Reset (async, immediate):
  - frameReg = all ones, so tx = 1.
  - baudCnt = 0, bitCnt = 0.
  - baudTickCounterDone = 0, bitCounterDone = 0.
- tx = frameReg[0], driven directly from the flop with no combinational path from inputs.
- load:
  - frameReg <= {1'b1 stop, [parity], dataIn, 1'b0 start}.
  - baudCnt <= 0, bitCnt <= 0.
  - tx goes low on the next cycle.
- shift (without load): frameReg <= {1'b1, frameReg[FRAME_W-1:1]}. Ones fill from the MSB, so tx returns high after the stop bit.
- Baud-tick counter:
  - Free-runs +1 per cycle.
  - Wraps from BAUD_DIV-1 to 0.
  - Cleared by load or resetBaudTickCounter; clear takes priority over wrap and increment.
- baudTickCounterDone = (baudCnt == BAUD_DIV-1). Combinational and high for exactly 1 cycle per BAUD_DIV cycles while uncleared.
- Bit counter:
  - incNumBits gives +1, saturating at FRAME_W-1 (no wrap).
  - load clears it and overrides incNumBits in the same cycle.
- bitCounterDone = baudTickCounterDone && (bitCnt == FRAME_W-1). Combinational.
- Priorities for simultaneous inputs: load > shift for frameReg; load > incNumBits for bitCnt. shift and incNumBits in the same cycle are both applied.
- A frame takes FRAME_W * BAUD_DIV cycles from load to bitCounterDone, given an FSM that pulses shift and incNumBits on each baudTickCounterDone.
- Reset mid-frame: tx goes high asynchronously and all counters clear; the partial frame is discarded.
- load mid-frame: the current frame is aborted and the new frame starts cleanly (start bit on the next cycle).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - FRAME_W grows by 1.
  - Parity bit = ^dataIn (XNOR instead if PARITY_ODD = 1), computed at load.
  - Parity sits between the data MSB and the stop bit.
- Undefined: no parity logic, FRAME_W = DATA_BITS + 2, and PARITY_ODD is ignored.

Test Plan:
- Reset:
  - Stimulus: assert reset mid-frame (after 3 bits sent).
  - Response: tx = 1 within the same cycle (async); both done flags 0; baudCnt = 0 after release.
- Frame shape:
  - Setup: BAUD_DIV = 4, DATA_BITS = 8, reference FSM model. Stimulus: load dataIn = 8'hA5.
  - Response: tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles wide; bitCounterDone pulses once at cycle 40 after load.
- Baud counter:
  - Stimulus: leave it free-running, then pulse resetBaudTickCounter when baudCnt = 2.
  - Response: baudTickCounterDone every 4th cycle; after the clear, the next pulse comes 4 cycles later.
- Priority:
  - Stimulus: load = 1, shift = 1, incNumBits = 1 in the same cycle with dataIn = 8'h00.
  - Response: frameReg = 10'b1000000000; bitCnt = 0; tx = 0 next cycle.
- Saturation:
  - Stimulus: 15 incNumBits pulses after load.
  - Response: bitCnt holds at 9; bitCounterDone is asserted only on baudTickCounterDone cycles.
- Parity (UART_TX_PARITY_EN defined, PARITY_ODD = 0):
  - Stimulus: load 8'h07.
  - Response: 11-bit frame with parity bit 1 before the stop bit; bitCounterDone at cycle 44.
